// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, ROM depth and fetch state type
package fetch_pkg;

    localparam int FETCH_ADDR_W = 4;
    localparam int FETCH_DATA_W = 49;
    localparam int ROM_DEPTH    = 1 << FETCH_ADDR_W;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// rtl/fetch_skid_fifo.sv - shift-register skid FIFO with registered head and synchronous clear
module fetch_skid_fifo #(
    parameter int  DEPTH = 3,
    parameter int  WIDTH = 53,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_pop;
    logic             do_push;
    logic [CNT_W-1:0] wr_idx;

    // Entry 0 is always the head; slots at or above count are kept zero so an
    // empty FIFO presents an all-zero head.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_idx  = do_pop ? (count_q - CNT_W'(1)) : count_q;
        mem_d   = mem_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            mem_d[DEPTH - 1] = '0;
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    mem_d[i] = push_data;
                end
            end
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head       = mem_q[0];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/rom_fetch_ctrl.sv
// rtl/rom_fetch_ctrl.sv - ROM instruction-fetch sequencer; FETCH_PERF_EN adds perf counters
module rom_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = FETCH_ADDR_W,
    parameter int               DATA_W   = FETCH_DATA_W,
    parameter int               ROM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clka,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              running,
    output logic [15:0]       perf_issued,
    output logic [15:0]       perf_killed
);

    localparam int DEPTH = ROM_LAT + 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ROM_LAT-1:0] vld_q;
    logic [ROM_LAT-1:0] vld_d;
    logic [ADDR_W-1:0] pcp_q [ROM_LAT];
    logic [ADDR_W-1:0] pcp_d [ROM_LAT];
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]  credit_used;
    logic              issue;

    // Reads in flight plus buffered words must leave room for one more fetch
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
        credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    end

    // State register
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: redirect always restarts fetching; halt drains then parks
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (halt) state_d = DRAIN;
                DRAIN:   if (inflight == '0) state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
    end

    // FSM outputs: running flag and fetch issue strobe
    always_comb begin
        running = (state_q == FETCH);
        issue   = running && !halt && !redirect_valid
                  && (credit_used < SUM_W'(DEPTH));
    end

    // Program counter and in-flight tracking pipe
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(1);
        end
        vld_d    = '0;
        vld_d[0] = issue;
        pcp_d[0] = pc_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            vld_d[i] = vld_q[i - 1];
            pcp_d[i] = pcp_q[i - 1];
        end
        if (redirect_valid) begin
            vld_d = '0;
        end
    end

    // PC and pipe registers
    always_ff @(posedge clka) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            vld_q <= '0;
            pcp_q <= '{default: '0};
        end else begin
            pc_q  <= pc_d;
            vld_q <= vld_d;
            pcp_q <= pcp_d;
        end
    end

    assign rom_addr = pc_q;

    fetch_skid_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .clk        (clka),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (vld_q[ROM_LAT-1]),
        .push_data  ({rom_data, pcp_q[ROM_LAT-1]}),
        .pop        (instr_ready),
        .head       ({instr, instr_pc}),
        .head_valid (instr_valid),
        .count      (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [15:0]      issued_q;
    logic [15:0]      issued_d;
    logic [15:0]      killed_q;
    logic [15:0]      killed_d;
    logic [SUM_W-1:0] killed_now;
    logic [16:0]      killed_sum;

    // Saturating counters; a word handed to decode on the redirect edge is not a kill
    always_comb begin
        issued_d = issued_q;
        if (issue && (issued_q != 16'hFFFF)) begin
            issued_d = issued_q + 16'd1;
        end
        killed_now = credit_used - SUM_W'(instr_valid && instr_ready);
        killed_sum = {1'b0, killed_q} + 17'(killed_now);
        killed_d   = killed_q;
        if (redirect_valid) begin
            killed_d = killed_sum[16] ? 16'hFFFF : killed_sum[15:0];
        end
    end

    // Performance counter registers
    always_ff @(posedge clka) begin
        if (rst) begin
            issued_q <= '0;
            killed_q <= '0;
        end else begin
            issued_q <= issued_d;
            killed_q <= killed_d;
        end
    end

    assign perf_issued = issued_q;
    assign perf_killed = killed_q;
`else
    assign perf_issued = '0;
    assign perf_killed = '0;
`endif

endmodule
